// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// One quotient bit is produced per clock. The pipeline is stalled while the
// divide is in flight. The result is returned as {remainder, quotient}.
// Optional build macro: DIV_ZERO_FLAG_EN adds a registered div_zero_o flag.
//   When it is defined, div_zero_o is raised with ready_o when the latched
//   divisor was zero.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stall_req_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                div_zero_o
`endif
);

  // The counter must be able to hold DATA_W itself (the "all bits done" value).
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  // dvd_reg starts as the (absolute) dividend. The remaining dividend bits
  // shift out of the top while quotient bits shift in at the bottom, so after
  // DATA_W steps it holds the unsigned quotient.
  logic [DATA_W-1:0]   dvd_reg, dvd_next;
  logic [DATA_W-1:0]   dvs_reg, dvs_next;
  logic [DATA_W-1:0]   rem_reg, rem_next;
  logic                neg_quot_reg, neg_quot_next;
  logic                neg_rem_reg, neg_rem_next;
  logic [2*DATA_W-1:0] result_reg, result_next;
  logic                ready_reg, ready_next;
`ifdef DIV_ZERO_FLAG_EN
  logic                dz_reg, dz_next;
`endif

  // Datapath helpers shared by the FSM.
  logic [DATA_W:0]     trial;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                op1_neg;
  logic                op2_neg;

  assign op1_neg = signed_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_i & opdata2_i[DATA_W-1];
  // For the most negative value the negation wraps back onto itself. That is
  // still the correct unsigned magnitude, so no special case is needed.
  assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

  // The partial remainder is always below the divisor. The widened trial value
  // therefore fits in DATA_W+1 bits. A clear top bit of diff means the
  // subtraction did not go negative.
  assign trial = {rem_reg, dvd_reg[DATA_W-1]};
  assign diff  = trial - {1'b0, dvs_reg};

  assign quot_fix = neg_quot_reg ? -dvd_reg : dvd_reg;
  assign rem_fix  = neg_rem_reg  ? -rem_reg : rem_reg;

  // Next-state and datapath update for the divide sequencer.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dvd_next      = dvd_reg;
    dvs_next      = dvs_reg;
    rem_next      = rem_reg;
    neg_quot_next = neg_quot_reg;
    neg_rem_next  = neg_rem_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;
`ifdef DIV_ZERO_FLAG_EN
    dz_next       = dz_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start_i && !annul_i) begin
          dvd_next      = op1_abs;
          dvs_next      = op2_abs;
          rem_next      = '0;
          cnt_next      = '0;
          neg_quot_next = op1_neg ^ op2_neg;
          neg_rem_next  = op1_neg;
          state_next    = (opdata2_i == '0) ? BYZERO : ON;
        end
      end

      BYZERO: begin
        if (annul_i) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          // Dwell for one extra edge so a zero divide always reports on the second edge after accept.
          cnt_next = CNT_W'(1);
        end else begin
          result_next = '0;
          ready_next  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
          dz_next     = 1'b1;
`endif
          state_next  = END;
        end
      end

      ON: begin
        if (annul_i) begin
          state_next = IDLE;
        end else if (cnt_reg != CNT_W'(DATA_W)) begin
          if (!diff[DATA_W]) begin
            rem_next = diff[DATA_W-1:0];
            dvd_next = {dvd_reg[DATA_W-2:0], 1'b1};
          end else begin
            rem_next = trial[DATA_W-1:0];
            dvd_next = {dvd_reg[DATA_W-2:0], 1'b0};
          end
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          result_next = {rem_fix, quot_fix};
          ready_next  = 1'b1;
          state_next  = END;
        end
      end

      END: begin
        if (!start_i || annul_i) begin
          result_next = '0;
          ready_next  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          dz_next     = 1'b0;
`endif
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers, with a synchronous reset that can abort a divide in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      rem_reg      <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_reg       <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dvd_reg      <= dvd_next;
      dvs_reg      <= dvs_next;
      rem_reg      <= rem_next;
      neg_quot_reg <= neg_quot_next;
      neg_rem_reg  <= neg_rem_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
`ifdef DIV_ZERO_FLAG_EN
      dz_reg       <= dz_next;
`endif
    end
  end

  assign result_o    = result_reg;
  assign ready_o     = ready_reg;
  // EX is released in the same cycle that ready_o goes high.
  assign stall_req_o = start_i & ~ready_reg & ~annul_i;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o  = dz_reg;
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq.
// It runs directed vectors, hand-written annul and reset sequences, and random divides.
// Random divides are checked against an arithmetic reference model.
module tb_div_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          annul_i;
  logic          signed_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          stall_req_o;
`ifdef DIV_ZERO_FLAG_EN
  logic          div_zero_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  div_seq #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_req_o(stall_req_o)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero_o (div_zero_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sgn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: truncating division, with the remainder taking the dividend's sign.
  // The result wraps to W bits. Division by zero gives zero.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // One full divide handshake. Start is held, the bench waits for ready, holds
  // for three cycles in END, and then drops start.
  task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string tag);
    int lat;
    int exp_lat;
    logic busy_ok;
    logic hold_ok;
    logic [2*W-1:0] got;
    exp_lat   = (b == '0) ? 2 : W + 1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    #1;
    chk({tag, " stall_accept"}, {63'd0, stall_req_o}, 64'd1);
    @(posedge clk); #1;                      // accept edge E0
    // Scramble the operands after accept. The divider must ignore these values.
    signed_i  = ~sgn;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    lat     = 0;
    busy_ok = 1'b1;
    while (ready_o !== 1'b1 && lat < 100) begin
      if (stall_req_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " stall_busy"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result_o, exp);
    chk({tag, " stall_at_ready"}, {63'd0, stall_req_o}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, " div_zero"}, {63'd0, div_zero_o}, {63'd0, (b == '0)});
`endif
    got     = result_o;
    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || result_o !== got) hold_ok = 1'b0;
    end
    chk({tag, " hold_end"}, {63'd0, hold_ok}, 64'd1);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ready_release"}, {63'd0, ready_o}, 64'd0);
    chk({tag, " result_release"}, result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, " div_zero_release"}, {63'd0, div_zero_o}, 64'd0);
`endif
    $display("div %s sgn=%0d a=%h b=%h -> %h lat=%0d", tag, sgn, a, b, got, lat);
  endtask

  initial begin
    logic sgn;
    logic [W-1:0] a, b;
    int ready_seen;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[2] = '{1'b0, 32'd5,          32'd0,        64'h00000000_00000000};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[4] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    vecs[5] = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, 64'hFFFFFFFE_00000002};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'h10,       64'h0000000F_0FFFFFFF};
    vecs[7] = '{1'b0, 32'd3,          32'd10,       64'h00000003_00000000};
    vecs[8] = '{1'b1, 32'd0,          32'd0,        64'h00000000_00000000};
    vecs[9] = '{1'b0, 32'h80000000,   32'd3,        64'h00000002_2AAAAAAA};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
    end
    #1;
    chk("reset result", result_o, 64'd0);
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset stall", {63'd0, stall_req_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Annul at E0+10: the divide is discarded and ready never rises.
    signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;                      // E0
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
    end
    #1;
    annul_i = 1'b1;
    #1;
    chk("annul stall", {63'd0, stall_req_o}, 64'd0);
    @(posedge clk); #1;                      // E0+10
    annul_i = 1'b0; start_i = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) ready_seen++;
    end
    chk("annul no_ready", 64'(ready_seen), 64'd0);
    $display("annul sequence done, ready_seen=%0d", ready_seen);
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after_annul");

    // Reset at E0+5 during a divide.
    signed_i = 1'b1; opdata1_i = 32'h12345678; opdata2_i = 32'h11; start_i = 1'b1;
    @(posedge clk); #1;                      // E0
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
    end
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;                      // E0+5
    chk("midrst result", result_o, 64'd0);
    chk("midrst ready", {63'd0, ready_o}, 64'd0);
    chk("midrst stall", {63'd0, stall_req_o}, 64'd0);
    rst = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) ready_seen++;
    end
    chk("midrst no_ready", 64'(ready_seen), 64'd0);
    $display("mid-divide reset sequence done, ready_seen=%0d", ready_seen);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "after_rst");

    // Random divides checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      do_div(sgn, a, b, model(sgn, a, b), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
